// File: rtl/css_mcu0_el2_pkg.sv
// Shared defaults and sizing helpers for the EL2 branch-predictor history/hash slice.
package css_mcu0_el2_pkg;

  localparam int BP_PC_W       = 32;
  localparam int BP_IDX_LO     = 1;
  localparam int BP_IDX_W      = 8;
  localparam int BP_IDX_FOLDS  = 2;
  localparam int BP_TAG_W      = 5;
  localparam int BP_TAG_FOLDS  = 3;
  localparam int BP_GHR_W      = 8;
  localparam int BP_CKPT_DEPTH = 4;

  // Occupancy counter must hold 0..depth inclusive.
  function automatic int ckpt_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/css_mcu0_el2_xor_fold.sv
// XOR-folds an IN_W-bit vector down to OUT_W bits; the input is zero-extended to whole chunks.
module css_mcu0_el2_xor_fold #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);

  localparam int NCH   = (IN_W + OUT_W - 1) / OUT_W;
  localparam int PAD_W = NCH * OUT_W;

  logic [NCH-1:0][OUT_W-1:0] chunks;

  assign chunks = PAD_W'(in_i);

  always_comb begin
    out_o = '0;
    for (int c = 0; c < NCH; c++) out_o = out_o ^ chunks[c];
  end

endmodule

// File: rtl/css_mcu0_el2_bp_hist_hash.sv
// Fetch-PC index/tag hashing plus speculative global history with checkpoint FIFO for recovery.
module css_mcu0_el2_bp_hist_hash
  import css_mcu0_el2_pkg::*;
#(
  parameter int PC_W       = BP_PC_W,
  parameter int IDX_LO     = BP_IDX_LO,
  parameter int IDX_W      = BP_IDX_W,
  parameter int IDX_FOLDS  = BP_IDX_FOLDS,
  parameter int TAG_W      = BP_TAG_W,
  parameter int TAG_FOLDS  = BP_TAG_FOLDS,
  parameter int GHR_W      = BP_GHR_W,
  parameter int CKPT_DEPTH = BP_CKPT_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                lookup_valid,
  input  logic [PC_W-1:0]                     lookup_pc,
  input  logic                                predict_valid,
  input  logic                                predict_taken,
  output logic                                predict_ready,
  input  logic                                commit_valid,
  input  logic                                mispredict_valid,
  input  logic                                actual_taken,
  output logic                                hash_valid,
  output logic [IDX_W-1:0]                    btb_idx,
  output logic [TAG_W-1:0]                    btb_tag,
  output logic [IDX_W-1:0]                    bht_idx,
  output logic [GHR_W-1:0]                    ghr_o,
  output logic [ckpt_cnt_w(CKPT_DEPTH)-1:0]   ckpt_count,
  output logic                                err_o
);

  localparam int CW       = ckpt_cnt_w(CKPT_DEPTH);
  localparam int PW       = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;
  localparam int IDX_SPAN = IDX_W * IDX_FOLDS;
  localparam int TAG_SPAN = TAG_W * TAG_FOLDS;
  localparam logic [CW-1:0] FULL_CNT = CW'(CKPT_DEPTH);

  if (IDX_LO + IDX_SPAN + TAG_SPAN > PC_W) begin : g_bad_pc_w
    $error("css_mcu0_el2_bp_hist_hash: index/tag folds exceed PC_W");
  end
  if (CKPT_DEPTH < 2 || (CKPT_DEPTH & (CKPT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("css_mcu0_el2_bp_hist_hash: CKPT_DEPTH must be a power of two >= 2");
  end
  if (GHR_W < 2) begin : g_bad_ghr
    $error("css_mcu0_el2_bp_hist_hash: GHR_W must be >= 2");
  end

  // ---------------- hashing ----------------
  logic [IDX_W-1:0] idx_fold, ghr_fold;
  logic [TAG_W-1:0] tag_fold;

  css_mcu0_el2_xor_fold #(.IN_W(IDX_SPAN), .OUT_W(IDX_W)) u_idx_fold (
    .in_i  (lookup_pc[IDX_LO +: IDX_SPAN]),
    .out_o (idx_fold)
  );

  css_mcu0_el2_xor_fold #(.IN_W(TAG_SPAN), .OUT_W(TAG_W)) u_tag_fold (
    .in_i  (lookup_pc[IDX_LO + IDX_SPAN +: TAG_SPAN]),
    .out_o (tag_fold)
  );

  logic [GHR_W-1:0] ghr_q, ghr_d;

  css_mcu0_el2_xor_fold #(.IN_W(GHR_W), .OUT_W(IDX_W)) u_ghr_fold (
    .in_i  (ghr_q),
    .out_o (ghr_fold)
  );

  logic             unused_pc_bits;
  assign unused_pc_bits = ^lookup_pc;

  logic             hash_valid_q;
  logic [IDX_W-1:0] btb_idx_q, bht_idx_q;
  logic [TAG_W-1:0] btb_tag_q;

  // The BHT index uses the history as it stood before this cycle's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      hash_valid_q <= 1'b0;
      btb_idx_q    <= '0;
      btb_tag_q    <= '0;
      bht_idx_q    <= '0;
    end else begin
      hash_valid_q <= lookup_valid;
      if (lookup_valid) begin
        btb_idx_q <= idx_fold;
        btb_tag_q <= tag_fold;
        bht_idx_q <= idx_fold ^ ghr_fold;
      end
    end
  end

  // ---------------- history + checkpoints ----------------
  logic [CKPT_DEPTH-1:0][GHR_W-1:0] ckpt_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          empty, full, mp_ok, push, pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign mp_ok = mispredict_valid & ~empty;
  assign push  = predict_valid & ~full & ~mispredict_valid;
  assign pop   = commit_valid & ~empty & ~mispredict_valid;

  always_comb begin
    ghr_d    = ghr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | ((commit_valid | mispredict_valid) & empty);
    if (mp_ok) begin
      // Recover from the oldest branch's snapshot, then append its real outcome.
      ghr_d    = {ckpt_q[rd_ptr_q][GHR_W-2:0], actual_taken};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        ghr_d    = {ghr_q[GHR_W-2:0], predict_taken};
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ghr_q    <= ghr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Snapshot storage needs no reset: it is only read while occupied.
  always_ff @(posedge clk) begin
    if (push) ckpt_q[wr_ptr_q] <= ghr_q;
  end

  assign predict_ready = ~full;
  assign hash_valid    = hash_valid_q;
  assign btb_idx       = btb_idx_q;
  assign btb_tag       = btb_tag_q;
  assign bht_idx       = bht_idx_q;
  assign ghr_o         = ghr_q;
  assign ckpt_count    = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_css_mcu0_el2_bp_hist_hash.sv
// Directed + random bench for the branch history/hash block with a hash scoreboard and history model.
module tb_css_mcu0_el2_bp_hist_hash;

  localparam int PC_W  = 32;
  localparam int IDX_W = 8;
  localparam int TAG_W = 5;
  localparam int GHR_W = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             lookup_valid = 1'b0;
  logic [PC_W-1:0]  lookup_pc = '0;
  logic             predict_valid = 1'b0, predict_taken = 1'b0;
  logic             commit_valid = 1'b0, mispredict_valid = 1'b0, actual_taken = 1'b0;
  logic             predict_ready, hash_valid, err_o;
  logic [IDX_W-1:0] btb_idx, bht_idx;
  logic [TAG_W-1:0] btb_tag;
  logic [GHR_W-1:0] ghr_o;
  logic [CW-1:0]    ckpt_count;

  css_mcu0_el2_bp_hist_hash dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_valid(predict_valid), .predict_taken(predict_taken), .predict_ready(predict_ready),
    .commit_valid(commit_valid), .mispredict_valid(mispredict_valid), .actual_taken(actual_taken),
    .hash_valid(hash_valid), .btb_idx(btb_idx), .btb_tag(btb_tag), .bht_idx(bht_idx),
    .ghr_o(ghr_o), .ckpt_count(ckpt_count), .err_o(err_o)
  );

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] bht;
  } hexp_t;

  hexp_t      expq[$];
  hexp_t      last_h;
  logic [7:0] cq[$];
  logic [7:0] ghr_m;
  logic       err_m;
  int         checks = 0;
  int         failures = 0;

  // Bitwise reference hash: output bit i collects every PC bit that lands on it.
  function automatic hexp_t ref_hash(input logic [31:0] pc, input logic [7:0] g);
    hexp_t h;
    h = '0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 2; k++) h.idx[i] = h.idx[i] ^ pc[1 + k*8 + i];
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 3; k++) h.tag[i] = h.tag[i] ^ pc[17 + k*5 + i];
    h.bht = h.idx;
    for (int j = 0; j < GHR_W; j++) h.bht[j % IDX_W] = h.bht[j % IDX_W] ^ g[j];
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    hexp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      last_h = e;
      chk("hash_valid", {31'b0, hash_valid}, 32'd1);
    end else begin
      chk("hash_valid_idle", {31'b0, hash_valid}, 32'd0);
    end
    chk("btb_idx", {24'b0, btb_idx}, {24'b0, last_h.idx});
    chk("btb_tag", {27'b0, btb_tag}, {27'b0, last_h.tag});
    chk("bht_idx", {24'b0, bht_idx}, {24'b0, last_h.bht});
    chk("ghr", {24'b0, ghr_o}, {24'b0, ghr_m});
    chk("ckpt_count", {29'b0, ckpt_count}, cq.size());
    chk("predict_ready", {31'b0, predict_ready}, {31'b0, (cq.size() < DEPTH)});
    chk("err", {31'b0, err_o}, {31'b0, err_m});
  endtask

  task automatic cycle(input logic lv, input logic [31:0] pc, input logic pv, input logic pt,
                       input logic cv, input logic mv, input logic at);
    logic acc, popm;
    lookup_valid = lv; lookup_pc = pc;
    predict_valid = pv; predict_taken = pt;
    commit_valid = cv; mispredict_valid = mv; actual_taken = at;
    if (lv) expq.push_back(ref_hash(pc, ghr_m));
    @(posedge clk); #1;
    if ((cv || mv) && cq.size() == 0) err_m = 1'b1;
    if (mv && cq.size() > 0) begin
      ghr_m = {cq[0][6:0], at};
      cq.delete();
    end else begin
      acc  = pv && (cq.size() < DEPTH) && !mv;
      popm = cv && (cq.size() > 0) && !mv;
      if (popm) void'(cq.pop_front());
      if (acc) begin
        cq.push_back(ghr_m);
        ghr_m = {ghr_m[6:0], pt};
      end
    end
    lookup_valid = 1'b0; predict_valid = 1'b0; commit_valid = 1'b0; mispredict_valid = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input logic busy);
    rst = 1'b1;
    lookup_valid = busy; lookup_pc = 32'hDEAD_BEEF;
    predict_valid = busy; predict_taken = 1'b1;
    commit_valid = busy; mispredict_valid = busy; actual_taken = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lookup_valid = 1'b0; predict_valid = 1'b0; commit_valid = 1'b0; mispredict_valid = 1'b0;
    ghr_m = '0; err_m = 1'b0; last_h = '0;
    cq.delete(); expq.delete();
    check_all();
  endtask

  initial begin
    ghr_m = '0; err_m = 1'b0; last_h = '0;
    @(posedge clk); #1;
    do_reset(1'b0);

    // Lookup hashing with zero history
    cycle(1, 32'h0001_FE02, 0, 0, 0, 0, 0);
    chk("req038_idx", {24'b0, btb_idx}, 32'hFE);
    chk("req038_tag", {27'b0, btb_tag}, 32'h00);
    chk("req038_bht", {24'b0, bht_idx}, 32'hFE);
    cycle(0, 32'h0, 0, 0, 0, 0, 0);  // hold when idle

    // T, T, N then recovery
    cycle(1, 32'h1234_5678, 1, 1, 0, 0, 0);
    chk("req039_ghr1", {24'b0, ghr_o}, 32'h01);
    cycle(1, 32'h8765_4321, 1, 1, 0, 0, 0);
    chk("req039_ghr2", {24'b0, ghr_o}, 32'h03);
    cycle(1, 32'hA5A5_5A5A, 1, 0, 0, 0, 0);
    chk("req039_ghr3", {24'b0, ghr_o}, 32'h06);
    chk("req039_cnt", {29'b0, ckpt_count}, 32'd3);
    cycle(1, 32'hFFFF_FFFF, 0, 0, 0, 1, 1);
    chk("req039_mp_ghr", {24'b0, ghr_o}, 32'h01);
    chk("req039_mp_cnt", {29'b0, ckpt_count}, 32'd0);

    // Fill to full, ignored predict, then drain one
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1, 1, 0, 0, 0);
    chk("req040_ready0", {31'b0, predict_ready}, 32'd0);
    chk("req040_ghr", {24'b0, ghr_o}, 32'h0F);
    cycle(1, 32'h0000_0100, 1, 0, 0, 0, 0);
    chk("req040_full_ghr", {24'b0, ghr_o}, 32'h0F);
    cycle(0, 32'h0, 0, 0, 1, 0, 0);
    chk("req040_ready1", {31'b0, predict_ready}, 32'd1);
    chk("req040_cnt", {29'b0, ckpt_count}, 32'd3);

    // Build count=2 with oldest checkpoint 0x05, then all three events at once
    do_reset(1'b0);
    cycle(0, 32'h0, 1, 1, 0, 0, 0);
    cycle(0, 32'h0, 1, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 1, 0, 0);
    cycle(0, 32'h0, 1, 1, 1, 0, 0);  // simultaneous push+pop
    chk("push_pop_cnt", {29'b0, ckpt_count}, 32'd1);
    cycle(0, 32'h0, 0, 0, 1, 0, 0);
    cycle(0, 32'h0, 1, 1, 0, 0, 0);
    cycle(0, 32'h0, 1, 0, 0, 0, 0);
    chk("req041_pre_cnt", {29'b0, ckpt_count}, 32'd2);
    cycle(1, 32'h0F0F_0F0F, 1, 1, 1, 1, 0);
    chk("req041_ghr", {24'b0, ghr_o}, 32'h0A);
    chk("req041_cnt", {29'b0, ckpt_count}, 32'd0);

    // Empty commit sets a sticky error; reset under full activity clears everything
    cycle(0, 32'h0, 0, 0, 1, 0, 0);
    chk("req042_err", {31'b0, err_o}, 32'd1);
    cycle(0, 32'h0, 1, 1, 0, 0, 0);
    cycle(0, 32'h0, 1, 0, 0, 0, 0);
    chk("req042_err_sticky", {31'b0, err_o}, 32'd1);
    chk("req042_cnt2", {29'b0, ckpt_count}, 32'd2);
    do_reset(1'b1);
    chk("req042_rst_ready", {31'b0, predict_ready}, 32'd1);
    chk("req042_rst_err", {31'b0, err_o}, 32'd0);

    // Random traffic exercises pointer wrap and interleaved events
    for (int i = 0; i < 80; i++)
      cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
